// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one register file between two clients, plus clear sequencing.
// Latency: grant is combinational; read data returns exactly 1 cycle after acceptance.
// Backpressure: cN_ready low holds the client off; no grants while busy or on a clear request.
//
// Ports:
//   clock, reset_enable         : clock and synchronous active-high reset
//   clear_req / clear_done/busy : register clear request, done pulse, sequencing busy flag
//   cN_valid/write/num1/num2/wval, cN_ready : client N request channel
//   cN_rvalid/out1/out2         : client N read response (outputs zeroed when not valid)
//   rf_*                        : register file control (get/set/reset) and read data
module regfile_arbiter #(
  parameter int WORD_SIZE     = 8,
  parameter int REG_ADDR_SIZE = 3,
  parameter int REG_NUM       = 8
) (
  input  logic                     clock,
  input  logic                     reset_enable,
  input  logic                     clear_req,
  output logic                     clear_done,
  output logic                     busy,
  input  logic                     c0_valid,
  input  logic                     c0_write,
  input  logic [REG_ADDR_SIZE-1:0] c0_num1,
  input  logic [REG_ADDR_SIZE-1:0] c0_num2,
  input  logic [WORD_SIZE-1:0]     c0_wval,
  output logic                     c0_ready,
  output logic                     c0_rvalid,
  output logic [WORD_SIZE-1:0]     c0_out1,
  output logic [WORD_SIZE-1:0]     c0_out2,
  input  logic                     c1_valid,
  input  logic                     c1_write,
  input  logic [REG_ADDR_SIZE-1:0] c1_num1,
  input  logic [REG_ADDR_SIZE-1:0] c1_num2,
  input  logic [WORD_SIZE-1:0]     c1_wval,
  output logic                     c1_ready,
  output logic                     c1_rvalid,
  output logic [WORD_SIZE-1:0]     c1_out1,
  output logic [WORD_SIZE-1:0]     c1_out2,
  output logic [REG_ADDR_SIZE-1:0] rf_num1,
  output logic [REG_ADDR_SIZE-1:0] rf_num2,
  output logic [REG_ADDR_SIZE-1:0] rf_set_num,
  output logic [WORD_SIZE-1:0]     rf_set_val,
  output logic                     rf_get_enable,
  output logic                     rf_set_enable,
  output logic                     rf_reset_enable,
  input  logic [WORD_SIZE-1:0]     rf_out1,
  input  logic [WORD_SIZE-1:0]     rf_out2
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   rr_ptr_q, rr_ptr_d;       // client favoured when both are valid
  logic   rsp_pend_q, rsp_pend_d;   // a read was accepted last cycle
  logic   rsp_id_q, rsp_id_d;       // owner of that read
  logic   busy_q, busy_d;
  logic   clear_done_q, clear_done_d;
  logic   rf_reset_q, rf_reset_d;

  logic                     grant0, grant1;
  logic                     sel_write;
  logic [REG_ADDR_SIZE-1:0] sel_num1, sel_num2;
  logic [WORD_SIZE-1:0]     sel_wval;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    rsp_pend_d    = 1'b0;
    rsp_id_d      = rsp_id_q;
    grant0        = 1'b0;
    grant1        = 1'b0;
    rf_num1       = '0;
    rf_num2       = '0;
    rf_set_num    = '0;
    rf_set_val    = '0;
    rf_get_enable = 1'b0;
    rf_set_enable = 1'b0;

    unique case (state_q)
      ST_INIT:  state_d = ST_IDLE;
      ST_CLEAR: state_d = ST_IDLE;
      ST_IDLE: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
        end else if (c0_valid && (!c1_valid || !rr_ptr_q)) begin
          grant0 = 1'b1;
        end else if (c1_valid) begin
          grant1 = 1'b1;
        end
      end
      default:  state_d = ST_INIT;
    endcase

    // Payload of whichever client won; only meaningful when a grant is given.
    sel_write = grant1 ? c1_write : c0_write;
    sel_num1  = grant1 ? c1_num1  : c0_num1;
    sel_num2  = grant1 ? c1_num2  : c0_num2;
    sel_wval  = grant1 ? c1_wval  : c0_wval;

    if (grant0 || grant1) begin
      rr_ptr_d = grant0;  // the other client gets priority next time
      if (sel_write) begin
        rf_set_enable = 1'b1;
        rf_set_num    = sel_num1;
        rf_set_val    = sel_wval;
      end else begin
        rf_get_enable = 1'b1;
        rf_num1       = sel_num1;
        rf_num2       = sel_num2;
        rsp_pend_d    = 1'b1;
        rsp_id_d      = grant1;
      end
    end

    // State-derived outputs are registered from the next state so they line up
    // with the state they describe.
    busy_d       = (state_d != ST_IDLE);
    clear_done_d = (state_d == ST_CLEAR);
    rf_reset_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset_enable) begin
      state_q      <= ST_INIT;
      rr_ptr_q     <= 1'b0;
      rsp_pend_q   <= 1'b0;
      rsp_id_q     <= 1'b0;
      busy_q       <= 1'b1;
      clear_done_q <= 1'b0;
      rf_reset_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      rsp_pend_q   <= rsp_pend_d;
      rsp_id_q     <= rsp_id_d;
      busy_q       <= busy_d;
      clear_done_q <= clear_done_d;
      rf_reset_q   <= rf_reset_d;
    end
  end

  // Register numbers beyond REG_NUM address nothing in the file.
  always_ff @(posedge clock) begin
    if (!reset_enable && rf_set_enable) assert (int'(rf_set_num) < REG_NUM);
    if (!reset_enable && rf_get_enable) assert (int'(rf_num1) < REG_NUM && int'(rf_num2) < REG_NUM);
  end

  assign c0_ready        = grant0;
  assign c1_ready        = grant1;
  assign busy            = busy_q;
  assign clear_done      = clear_done_q;
  assign rf_reset_enable = rf_reset_q;

  // Read data arrives from the file one cycle after the get; steer it to its owner.
  assign c0_rvalid = rsp_pend_q && !rsp_id_q;
  assign c1_rvalid = rsp_pend_q && rsp_id_q;
  assign c0_out1   = c0_rvalid ? rf_out1 : '0;
  assign c0_out2   = c0_rvalid ? rf_out2 : '0;
  assign c1_out1   = c1_rvalid ? rf_out1 : '0;
  assign c1_out2   = c1_rvalid ? rf_out2 : '0;

endmodule
